// File: rtl/conv_window_mac_if.sv
// Stream/weight bundle for conv_window_mac: column input, weight load, result output.
interface conv_window_mac_if #(
  parameter int DATA_WIDTH = 16,
  parameter int K          = 5,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K*K)
);
  logic                            cw_en;
  logic                            cw_clr;
  logic [K-1:0][DATA_WIDTH-1:0]    cw_rows_i;
  logic                            cw_wt_ld;
  logic [K*K-1:0][DATA_WIDTH-1:0]  cw_wt_i;
  logic [ACC_WIDTH-1:0]            cw_out_o;
  logic                            cw_vld_o;
  logic                            cw_last_o;

  // Upstream / testbench side.
  modport master (output cw_en, cw_clr, cw_rows_i, cw_wt_ld, cw_wt_i,
                  input  cw_out_o, cw_vld_o, cw_last_o);
  // Convolution block side.
  modport slave  (input  cw_en, cw_clr, cw_rows_i, cw_wt_ld, cw_wt_i,
                  output cw_out_o, cw_vld_o, cw_last_o);
endinterface

// File: rtl/conv_window_mac.sv
// KxK sliding window + element-wise signed multiply + adder tree.
// Valid-mode convolution: only windows fully inside the frame produce a result.
// Pipeline: window/stage0 -> products -> sum/output, free-running.
module conv_window_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int K          = 5,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K*K)
) (
  input logic               cw_clk,
  input logic               cw_rst_b,
  conv_window_mac_if.slave  cw
);
  localparam int PW     = 2*DATA_WIDTH;
  localparam int NT     = K*K;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int STAGES = 2;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W-1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H-1);
  localparam logic [CW-1:0] COL_FIRST = CW'(K-1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K-1);

  // win[r][c]: r = rows above current, c = columns back (0 = newest)
  logic [K-1:0][K-1:0][DATA_WIDTH-1:0] win_q, win_d;
  logic [NT-1:0][DATA_WIDTH-1:0]       wt_q, wt_d;
  logic [CW-1:0]                       col_q, col_d;
  logic [RW-1:0]                       row_q, row_d;
  logic [NT-1:0][PW-1:0]               prod_q, prod_d;
  logic [ACC_WIDTH-1:0]                out_q, out_d;
  logic [STAGES:0]                     vld_pipe_q, vld_pipe_d;
  logic [STAGES:0]                     last_pipe_q, last_pipe_d;

  logic win_vld, win_last;

  // Window shift, position counters, weight bank and flag pipeline.
  always_comb begin
    win_d    = win_q;
    col_d    = col_q;
    row_d    = row_q;
    wt_d     = cw.cw_wt_ld ? cw.cw_wt_i : wt_q;
    win_vld  = cw.cw_en && (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
    win_last = win_vld && (row_q == ROW_LAST) && (col_q == COL_LAST);
    vld_pipe_d  = {vld_pipe_q[STAGES-1:0],  win_vld};
    last_pipe_d = {last_pipe_q[STAGES-1:0], win_last};
    if (cw.cw_clr) begin
      // Frame restart wins over a same-cycle accept; weights survive.
      win_d       = '0;
      col_d       = '0;
      row_d       = '0;
      vld_pipe_d  = '0;
      last_pipe_d = '0;
    end else if (cw.cw_en) begin
      for (int r = 0; r < K; r++) begin
        for (int c = K-1; c > 0; c--) win_d[r][c] = win_q[r][c-1];
        win_d[r][0] = cw.cw_rows_i[r];
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Stage 1 products; each operand is sign-extended to full product width.
  always_comb begin
    prod_d = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        prod_d[r*K+c] = PW'($signed(win_q[r][c])) * PW'($signed(wt_q[r*K+c]));
  end

  // Stage 2 sum; ACC_WIDTH leaves enough headroom that the sum never wraps.
  always_comb begin
    out_d = '0;
    for (int i = 0; i < NT; i++)
      out_d = out_d + ACC_WIDTH'($signed(prod_q[i]));
  end

  // All state registers; async active-low reset clears everything.
  always_ff @(posedge cw_clk or negedge cw_rst_b) begin
    if (!cw_rst_b) begin
      win_q       <= '0;
      wt_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      prod_q      <= '0;
      out_q       <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
    end else begin
      win_q       <= win_d;
      wt_q        <= wt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      prod_q      <= prod_d;
      out_q       <= out_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
    end
  end

  assign cw.cw_out_o  = out_q;
  assign cw.cw_vld_o  = vld_pipe_q[STAGES];
  assign cw.cw_last_o = last_pipe_q[STAGES];

endmodule

// File: doc/conv_window_mac.md
# conv_window_mac

Convolution window and multiply-accumulate stage for CNN layer 1. It sits directly downstream of the row line buffer and consumes one column of K vertically aligned pixels per accepted cycle. It assembles a KxK sliding window, multiplies it element-wise by a KxK signed weight set, and sums the products through a pipelined adder. It emits one convolution result per fully valid window position, so edge positions are suppressed (valid-mode convolution) and the output is (IMG_H-K+1)x(IMG_W-K+1) per frame.

## Interface
- DATA_WIDTH, 16: signed pixel and weight width.
- K, 5: kernel size (KxK window).
- IMG_W, 32: image width in pixels.
- IMG_H, 32: image height in pixels.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(K*K): result width; sized so that no overflow occurs.

Ports:
- cw_clk  in  1  clock.
- cw_rst_b  in  1  reset, asynchronous, active-low.
- cw_en  in  1  pixel-column accept strobe (driven by the same source as the line-buffer enable).
- cw_clr  in  1  synchronous frame restart.
- cw_rows_i  in  [K-1:0][DATA_WIDTH-1:0]  pixel column. Index 0 is the current row; index r is the pixel r rows above, at the same column.
- cw_wt_ld  in  1  weight load strobe.
- cw_wt_i  in  [K*K-1:0][DATA_WIDTH-1:0]  weights. Index r*K+c multiplies the window element at row offset r and column offset c, where c=0 is the newest column.
- cw_out_o  out  [ACC_WIDTH-1:0]  signed convolution result.
- cw_vld_o  out  1  cw_out_o valid, one-cycle pulse per result.
- cw_last_o  out  1  asserted together with cw_vld_o on the final result of the frame.

## Operation
- **Window.** On each clk edge with cw_en=1, for every r:
  - win[r][c] <= win[r][c-1] for c=1..K-1;
  - win[r][0] <= cw_rows_i[r].
- **Position counters.** col (0..IMG_W-1) and row (0..IMG_H-1) hold the position of the pixel in cw_rows_i[0].
  - Both advance on each accept.
  - col wraps to 0 and increments row.
  - After (IMG_H-1, IMG_W-1), both wrap to 0, which starts the next frame with no idle cycle required.
- **Window valid.** Stage-0 valid is registered with the window and equals cw_en && row>=K-1 && col>=K-1, evaluated on the pre-increment counters. Stage-0 last equals stage-0 valid && row==IMG_H-1 && col==IMG_W-1.
- **Weights.** A weight register bank loads cw_wt_i on an edge where cw_wt_ld=1. It holds its value otherwise.
- **Pipeline.** The pipeline is free-running (it does not stall on cw_en), and valid/last travel alongside the data.
  - Stage 1: K*K products win*wt, signed, 2*DATA_WIDTH wide, registered.
  - Stage 2: sum of all products, sign-extended to ACC_WIDTH, registered into cw_out_o, cw_vld_o and cw_last_o.
- **Arithmetic.** Two's-complement signed throughout, with no saturation or rounding. The result is the exact sum.
- **cw_clr.**
  - Zeroes row, col, the window and all stage valid/last bits on the next edge.
  - Weights are retained.
  - If cw_en is asserted in the same cycle, cw_clr wins and that column is dropped.
- **Reset.** All registers are zeroed: window, weights, counters, pipeline data and flags. cw_out_o, cw_vld_o and cw_last_o are all 0 during and after reset.
- **Upstream alignment.** The upstream stage guarantees row alignment of cw_rows_i. This block does not check it.

## Timing
- **Latency.** A column accepted at edge t appears as follows:
  - window and stage-0 valid update at edge t;
  - products register at edge t+1;
  - the result registers at edge t+2.
  - cw_vld_o is therefore high in the cycle following edge t+2, i.e. 3 cycles after the cycle in which cw_en was sampled high.
- **Throughput.** One result per cycle when cw_en=1 continuously. Gaps in cw_en produce matching gaps in cw_vld_o, with constant latency.
- **Weight load timing.** With cw_wt_ld at edge t, products registered at edge t+1 and later use the new weights. This includes the column accepted at edge t.
- **Results per frame.** Exactly (IMG_H-K+1)*(IMG_W-K+1). The first result is for the column where row=K-1, col=K-1.
- **cw_clr in flight.** cw_clr at edge t kills any result that would have appeared after edge t.

## Test plan
- **Reset:** assert cw_rst_b low mid-frame, asynchronously -> all outputs 0 immediately. After release, the next frame yields the full result count.
- **All ones:** K=5, IMG_W=IMG_H=8, all pixels and weights =1, cw_en constant -> first cw_vld_o 3 cycles after accept #36 (row 4, col 4), value 25. There are 16 results per frame, and cw_last_o is set only on the 16th.
- **Weight indexing:** weight 1 at index r*K+c and 0 elsewhere, ramp pixels p=row*IMG_W+col -> every result equals the pixel at (row-r, col-c) relative to the current column.
- **Signed extreme:** all pixels and weights =-32768 -> every result = 25*2^30 = 26843545600 in 37-bit two's complement, with no wrap.
- **Enable gaps:** random 50% cw_en over 2 frames -> results are identical to the gap-free run, each 3 cycles after its accepting cycle, and cw_vld_o never pulses without a corresponding accept.
- **Clear collision:** cw_clr and cw_en together in the cycle 2 cycles after the first valid accept -> the column is dropped, the one pending result (not yet on the output) is killed, and the following frame starts from row 0, col 0 with the correct count.
